imem_loader: RTL
================

Name: imem_loader

Overview:
- Hardware program loader that fills the single-cycle CPU's instruction memory from a byte stream, then releases the CPU.
- It replaces simulation-only preloading. It zero-fills the whole memory, packs incoming bytes big-endian into 32-bit words, and writes them to consecutive word addresses from 0.
- It sits between a host byte source (UART/debug port) and the instruction memory write port. It drives the CPU start input.

Parameters:
- ADDR_WIDTH, 7, word-address width; memory depth DEPTH = 2**ADDR_WIDTH (128 words).
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8 (BYTES = DATA_WIDTH/8).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- load_start_i  in  1  one-cycle pulse; begins a load session. Sampled only in IDLE or DONE.
- load_len_i  in  ADDR_WIDTH+1  number of words to load; sampled with load_start_i.
- byte_valid_i  in  1  host byte valid.
- byte_data_i  in  8  host byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- mem_we_o  out  1  instruction memory write enable.
- mem_addr_o  out  ADDR_WIDTH  word address.
- mem_wdata_o  out  DATA_WIDTH  write data.
- cpu_start_o  out  1  CPU start; low while loading, high after a completed load.
- busy_o  out  1  high in CLEAR/RECV/WRITE.
- done_o  out  1  high in DONE.
- err_o  out  1  one-cycle pulse on a rejected load_start_i.

Behaviour:
- Reset values: all outputs 0. State IDLE, address counter 0, word counter 0, byte index 0.
- A byte transfers when byte_valid_i && byte_ready_o. byte_ready_o is high only in RECV. It is combinational from state only, never from byte_valid_i.
- IDLE or DONE, load_start_i=1:
  - If load_len_i==0 or load_len_i>DEPTH: err_o=1 next cycle; state is unchanged (DONE keeps cpu_start_o=1).
  - Otherwise: latch the length, cpu_start_o=0 next cycle, go to CLEAR.
- CLEAR: mem_we_o=1, mem_wdata_o=0, mem_addr_o counts 0..DEPTH-1, one word per cycle (DEPTH cycles). After address DEPTH-1: address returns to 0, go to RECV.
- RECV: each accepted byte shifts in big-endian. The first byte goes to bits DATA_WIDTH-1:DATA_WIDTH-8. On the BYTES-th accepted byte, go to WRITE.
- WRITE: exactly one cycle. mem_we_o=1, mem_addr_o=current address, mem_wdata_o=packed word, byte_ready_o=0. The word counter then increments.
  - If the count equals the latched length: go to DONE.
  - Otherwise: address+1, go to RECV.
- DONE: cpu_start_o=1, done_o=1, mem_we_o=0. Held until reset or a valid load_start_i.
- mem_we_o is 0 in IDLE, RECV, and DONE. mem_addr_o and mem_wdata_o are don't-care when mem_we_o=0, but must hold their last value.
- load_start_i during CLEAR/RECV/WRITE is ignored; err_o is not asserted.
- Host gaps (byte_valid_i low) in RECV stall indefinitely. There is no timeout.
- Reset mid-session: next cycle is IDLE with all outputs 0. A partial word is discarded and memory contents are left as written.
- Full load (len=DEPTH): last write is at address DEPTH-1. The address counter must not wrap before DONE.
- Load latency, zero-gap host: DEPTH + len*(BYTES+1) cycles from load_start_i to done_o.

Decomposition:
- Package imem_loader_pkg:
  - state enum {IDLE, CLEAR, RECV, WRITE, DONE}
  - BYTE_WIDTH=8 constant
  - localparam function for BYTES
- Sub-module imem_word_packer: byte shift register plus byte-index counter.
  - Inputs: shift enable, byte, clear.
  - Outputs: word, word_complete.
  - Instantiated once. The FSM, address counter, and word counter stay in imem_loader.

Test Plan:
- Reset, then load_start_i with len=2, bytes 8C,08,00,00,20,09,00,05, no gaps. Required:
  - 128 zero writes at addr 0..127.
  - Write 0x8C080000 @0, then 0x20090005 @1.
  - done_o=1 and cpu_start_o=1 at cycle 128+10 after the start pulse.
- Same 2-word load with byte_valid_i toggling 1/0 every cycle:
  - Identical memory writes.
  - byte_ready_o low in WRITE cycles.
  - No byte lost or duplicated.
- load_len_i=0, then load_len_i=129:
  - err_o pulses one cycle each.
  - No mem_we_o.
  - State stays IDLE and cpu_start_o stays 0.
- len=128 with bytes forming word value = index:
  - Last write is 0x0000007F @127.
  - done_o asserts.
  - No write to address 0 after CLEAR apart from word 0.
- Assert rst_i after 2 bytes of word 1 in a len=3 load:
  - Next cycle all outputs 0.
  - A new len=1 load completes normally with a fresh packer (first byte lands in MSBs).
- From DONE, issue a new load_start_i with len=1:
  - cpu_start_o drops the next cycle.
  - CLEAR reruns.
  - cpu_start_o rises again after the single write.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RECV  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BYTE_WIDTH = 8;

  // Number of host bytes that make up one instruction word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte packer: shifts host bytes into a word, first byte ends up in the MSBs.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  shift_en_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_complete_o
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  // Shift the next byte in and flag the byte that completes a word.
  always_comb begin
    idx_d           = idx_q;
    word_d          = word_q;
    word_complete_o = 1'b0;
    if (clear_i) begin
      idx_d = '0;
    end else if (shift_en_i) begin
      word_d = (word_q << BYTE_WIDTH) | DATA_WIDTH'(byte_i);
      if (idx_q == IDX_W'(BYTES - 1)) begin
        idx_d           = '0;
        word_complete_o = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Byte index is control state and restarts on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Word contents are fully overwritten before use, so no reset is needed.
  always_ff @(posedge clk_i) begin
    word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: zero-fills the memory, then writes packed host words
// from address 0 and releases the CPU once the requested number of words is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_start_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;

  logic                  start_req;
  logic                  len_ok;
  logic                  pk_shift;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  pk_complete;

  // A start request is only honoured while idle or finished.
  assign start_req = load_start_i && ((state_q == IDLE) || (state_q == DONE));
  assign len_ok    = (load_len_i != '0) && (load_len_i <= DEPTH_L);
  assign pk_shift  = (state_q == RECV) && byte_valid_i;

  imem_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (start_req && len_ok),
    .shift_en_i      (pk_shift),
    .byte_i          (byte_data_i),
    .word_o          (pk_word),
    .word_complete_o (pk_complete)
  );

  assign byte_ready_o = (state_q == RECV);
  assign mem_we_o     = (state_q == CLEAR) || (state_q == WRITE);
  assign busy_o       = (state_q == CLEAR) || (state_q == RECV) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign cpu_start_o  = (state_q == DONE);
  assign err_o        = err_q;

  // Memory address/data follow the active write and otherwise hold the last written value.
  always_comb begin
    mem_addr_o  = hold_addr_q;
    mem_wdata_o = hold_wdata_q;
    if (state_q == CLEAR) begin
      mem_addr_o  = addr_q;
      mem_wdata_o = '0;
    end else if (state_q == WRITE) begin
      mem_addr_o  = addr_q;
      mem_wdata_o = pk_word;
    end
  end

  // Session sequencing: clear sweep, byte reception, word write, completion.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    len_d        = len_q;
    err_d        = 1'b0;
    hold_addr_d  = mem_addr_o;
    hold_wdata_d = mem_wdata_o;
    case (state_q)
      IDLE, DONE: begin
        if (start_req) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else begin
            len_d      = load_len_i;
            addr_d     = '0;
            word_cnt_d = '0;
            state_d    = CLEAR;
          end
        end
      end
      CLEAR: begin
        // Natural wrap brings the address back to 0 for the first data word.
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (addr_q == LAST_ADDR) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (pk_complete) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + (ADDR_WIDTH + 1)'(1);
        // The address is not advanced after the final word, so a full load never wraps.
        if (word_cnt_d == len_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file for state, counters and held memory outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      err_q        <= err_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

endmodule
